// File: rtl/btb_pkg.sv
// Shared helpers for the set-associative BTB: address-split arithmetic,
// update-action encoding and the saturating counter step.
package btb_pkg;

    localparam int unsigned CNT_MAX_W = 4;

    typedef enum logic [1:0] {
        UPD_NONE,
        UPD_HIT,
        UPD_ALLOC
    } upd_op_t;

    function automatic int unsigned idx_bits(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_lsb(input int unsigned idx_lsb, input int unsigned sets);
        return idx_lsb + $clog2(sets);
    endfunction

    // A single-way build still needs a 1-bit pointer to keep every port non-empty.
    function automatic int unsigned ptr_bits(input int unsigned ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic logic [CNT_MAX_W-1:0] cnt_next(input logic [CNT_MAX_W-1:0] cnt,
                                                      input logic taken,
                                                      input int unsigned width);
        logic [CNT_MAX_W-1:0] top;
        top = CNT_MAX_W'((1 << width) - 1);
        if (taken)
            return (cnt == top) ? cnt : cnt + 1'b1;
        else
            return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// IF-stage prediction and EXE-stage training signals of the BTB.
interface btb_assoc_if #(
    parameter int unsigned ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] pc_if;
    logic                  pred_hit_if;
    logic                  pred_taken_if;
    logic [ADDR_WIDTH-1:0] pred_target_if;
    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic                  upd_taken;
    logic [ADDR_WIDTH-1:0] upd_target;

    modport master (
        output pc_if, upd_valid, upd_pc, upd_taken, upd_target,
        input  pred_hit_if, pred_taken_if, pred_target_if
    );

    modport slave (
        input  pc_if, upd_valid, upd_pc, upd_taken, upd_target,
        output pred_hit_if, pred_taken_if, pred_target_if
    );
endinterface

// File: rtl/btb_way_sel.sv
// Per-set way selection: tag match over valid ways, plus the allocation
// choice (lowest invalid way, else the round-robin victim).
module btb_way_sel #(
    parameter int unsigned WAYS  = 2,
    parameter int unsigned TAG_W = 1,
    parameter int unsigned PTR_W = 1
) (
    input  logic [WAYS-1:0]            valid,
    input  logic [WAYS-1:0][TAG_W-1:0] tags,
    input  logic [TAG_W-1:0]           tag,
    input  logic [PTR_W-1:0]           victim,
    output logic                       hit,
    output logic [PTR_W-1:0]           hit_way,
    output logic [PTR_W-1:0]           alloc_way
);

    logic found;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        alloc_way = victim;
        found     = 1'b0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[w] && tags[w] == tag) begin
                hit     = 1'b1;
                hit_way = PTR_W'(w);
            end
            if (!valid[w] && !found) begin
                found     = 1'b1;
                alloc_way = PTR_W'(w);
            end
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational IF lookup, EXE training with
// allocate-on-taken, round-robin victims and single-cycle flush.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int unsigned SETS       = 16,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 2,
    parameter int unsigned IDX_LSB    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    btb_assoc_if.slave  bus
);

    localparam int unsigned IDX_W   = idx_bits(SETS);
    localparam int unsigned TAG_LSB = tag_lsb(IDX_LSB, SETS);
    localparam int unsigned TAG_W   = ADDR_WIDTH - TAG_LSB;
    localparam int unsigned PTR_W   = ptr_bits(WAYS);
    localparam logic [CNT_WIDTH-1:0] WEAK_TAKEN = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

    typedef struct packed {
        logic                  valid;
        logic [TAG_W-1:0]      tag;
        logic [ADDR_WIDTH-1:0] target;
        logic [CNT_WIDTH-1:0]  cnt;
    } btb_entry_t;

    btb_entry_t       ent    [SETS][WAYS];
    logic [PTR_W-1:0] victim [SETS];
    logic             stall_q;

    logic [IDX_W-1:0]            lk_idx, up_idx;
    logic [TAG_W-1:0]            lk_tag, up_tag;
    logic [WAYS-1:0]             lk_valid, up_valid;
    logic [WAYS-1:0][TAG_W-1:0]  lk_tags, up_tags;
    logic                        lk_hit, up_hit;
    logic [PTR_W-1:0]            lk_way, up_way, up_alloc, unused_lk_alloc;
    upd_op_t                     op;

    assign lk_idx = bus.pc_if[IDX_LSB +: IDX_W];
    assign lk_tag = bus.pc_if[ADDR_WIDTH-1:TAG_LSB];
    assign up_idx = bus.upd_pc[IDX_LSB +: IDX_W];
    assign up_tag = bus.upd_pc[ADDR_WIDTH-1:TAG_LSB];

    generate
        if (IDX_LSB > 0) begin : g_low_bits
            logic unused_low;
            assign unused_low = ^{bus.pc_if[IDX_LSB-1:0], bus.upd_pc[IDX_LSB-1:0]};
        end
    endgenerate

    always_comb begin
        lk_valid = '0;
        lk_tags  = '0;
        up_valid = '0;
        up_tags  = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            lk_valid[w] = ent[lk_idx][w].valid;
            lk_tags[w]  = ent[lk_idx][w].tag;
            up_valid[w] = ent[up_idx][w].valid;
            up_tags[w]  = ent[up_idx][w].tag;
        end
    end

    btb_way_sel #(.WAYS(WAYS), .TAG_W(TAG_W), .PTR_W(PTR_W)) u_sel_if (
        .valid     (lk_valid),
        .tags      (lk_tags),
        .tag       (lk_tag),
        .victim    (victim[lk_idx]),
        .hit       (lk_hit),
        .hit_way   (lk_way),
        .alloc_way (unused_lk_alloc)
    );

    btb_way_sel #(.WAYS(WAYS), .TAG_W(TAG_W), .PTR_W(PTR_W)) u_sel_exe (
        .valid     (up_valid),
        .tags      (up_tags),
        .tag       (up_tag),
        .victim    (victim[up_idx]),
        .hit       (up_hit),
        .hit_way   (up_way),
        .alloc_way (up_alloc)
    );

    assign bus.pred_hit_if    = lk_hit;
    assign bus.pred_taken_if  = lk_hit & ent[lk_idx][lk_way].cnt[CNT_WIDTH-1];
    assign bus.pred_target_if = lk_hit ? ent[lk_idx][lk_way].target : '0;

    // stall_q gates acceptance so the repeated EXE presentation after a stall is dropped.
    always_comb begin
        op = UPD_NONE;
        if (bus.upd_valid && !stall_q) begin
            if (up_hit)
                op = UPD_HIT;
            else if (bus.upd_taken)
                op = UPD_ALLOC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                victim[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++)
                    ent[s][w] <= '0;
            end
        end else begin
            stall_q <= stall;
            if (flush) begin
                for (int unsigned s = 0; s < SETS; s++) begin
                    victim[s] <= '0;
                    for (int unsigned w = 0; w < WAYS; w++)
                        ent[s][w].valid <= 1'b0;
                end
            end else begin
                case (op)
                    UPD_HIT: begin
                        ent[up_idx][up_way].cnt <= CNT_WIDTH'(cnt_next(
                            CNT_MAX_W'(ent[up_idx][up_way].cnt), bus.upd_taken, CNT_WIDTH));
                        if (bus.upd_taken)
                            ent[up_idx][up_way].target <= bus.upd_target;
                    end
                    UPD_ALLOC: begin
                        ent[up_idx][up_alloc] <= '{valid: 1'b1, tag: up_tag,
                                                   target: bus.upd_target, cnt: WEAK_TAKEN};
                        if (&up_valid)
                            victim[up_idx] <= PTR_W'((32'(victim[up_idx]) + 1) % WAYS);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed test-plan sequence with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_btb_assoc;

    localparam int unsigned SETS = 16;
    localparam int unsigned WAYS = 2;
    localparam int unsigned AW   = 64;
    localparam int unsigned CW   = 2;
    localparam int unsigned ILSB = 1;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic stall;
    logic flush;

    int n_checks = 0;
    int n_pass   = 0;

    btb_assoc_if #(.ADDR_WIDTH(AW)) bus ();

    btb_assoc #(.SETS(SETS), .WAYS(WAYS), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .IDX_LSB(ILSB)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: each set is a small table of (tag, target, counter) entries.
    bit          m_valid  [SETS][WAYS];
    bit [AW-1:0] m_tag    [SETS][WAYS];
    bit [AW-1:0] m_target [SETS][WAYS];
    int          m_cnt    [SETS][WAYS];
    int          m_victim [SETS];
    bit          m_stall;

    function automatic int set_of(input logic [AW-1:0] pc);
        return int'((pc >> ILSB) % SETS);
    endfunction

    function automatic logic [AW-1:0] tag_of(input logic [AW-1:0] pc);
        return pc >> (ILSB + $clog2(SETS));
    endfunction

    task automatic m_clear(input bit all);
        for (int s = 0; s < SETS; s++) begin
            m_victim[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                if (all) begin
                    m_tag[s][w]    = '0;
                    m_target[s][w] = '0;
                    m_cnt[s][w]    = 0;
                end
            end
        end
    endtask

    task automatic m_lookup(input logic [AW-1:0] pc, output bit h, output bit t, output logic [AW-1:0] tg);
        int s;
        s  = set_of(pc);
        h  = 1'b0;
        t  = 1'b0;
        tg = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) begin
                h  = 1'b1;
                t  = (m_cnt[s][w] >= (1 << (CW - 1)));
                tg = m_target[s][w];
            end
    endtask

    task automatic m_step();
        bit acc;
        int s, hw, aw;
        acc     = bus.upd_valid && !m_stall;
        m_stall = stall;
        if (flush) begin
            m_clear(1'b0);
        end else if (acc) begin
            s  = set_of(bus.upd_pc);
            hw = -1;
            for (int w = 0; w < WAYS; w++)
                if (m_valid[s][w] && m_tag[s][w] == tag_of(bus.upd_pc)) hw = w;
            if (hw >= 0) begin
                if (bus.upd_taken) begin
                    if (m_cnt[s][hw] < CMAX) m_cnt[s][hw]++;
                    m_target[s][hw] = bus.upd_target;
                end else if (m_cnt[s][hw] > 0) begin
                    m_cnt[s][hw]--;
                end
            end else if (bus.upd_taken) begin
                aw = -1;
                for (int w = WAYS - 1; w >= 0; w--)
                    if (!m_valid[s][w]) aw = w;
                if (aw < 0) begin
                    aw = m_victim[s];
                    m_victim[s] = (m_victim[s] + 1) % WAYS;
                end
                m_valid[s][aw]  = 1'b1;
                m_tag[s][aw]    = tag_of(bus.upd_pc);
                m_target[s][aw] = bus.upd_target;
                m_cnt[s][aw]    = 1 << (CW - 1);
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_clear(1'b1);
            m_stall = 1'b0;
        end else begin
            m_step();
        end
    end

    task automatic check(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, got, exp);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit          eh, et;
        logic [AW-1:0] etg;
        m_lookup(bus.pc_if, eh, et, etg);
        check("model_hit",    AW'(bus.pred_hit_if),   AW'(eh));
        check("model_taken",  AW'(bus.pred_taken_if), AW'(et));
        check("model_target", bus.pred_target_if,     etg);
    end

    task automatic look(input string name, input logic [AW-1:0] pc,
                        input bit h, input bit t, input logic [AW-1:0] tg);
        bus.pc_if = pc;
        #1;
        check({name, "_hit"},    AW'(bus.pred_hit_if),   AW'(h));
        check({name, "_taken"},  AW'(bus.pred_taken_if), AW'(t));
        check({name, "_target"}, bus.pred_target_if,     tg);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [AW-1:0] pc, input bit taken, input logic [AW-1:0] tg);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = tg;
        idle();
        bus.upd_valid  = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        idle();
        flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        bus.pc_if = 64'h100;
        bus.upd_valid = 1'b0;
        bus.upd_pc = '0;
        bus.upd_taken = 1'b0;
        bus.upd_target = '0;
        repeat (2) @(posedge clk);
        #1;
        look("reset", 64'h100, 0, 0, 64'h0);
        rst = 1'b0;
        idle();

        upd(64'h100, 1, 64'h200);
        look("alloc", 64'h100, 1, 1, 64'h200);
        upd(64'h100, 0, 64'h999);
        upd(64'h100, 0, 64'h999);
        look("cnt0", 64'h100, 1, 0, 64'h200);

        do_flush();
        upd(64'h100, 1, 64'h210);
        upd(64'h120, 1, 64'h220);
        upd(64'h140, 1, 64'h240);
        look("evict0_old", 64'h100, 0, 0, 64'h0);
        look("evict0_w1",  64'h120, 1, 1, 64'h220);
        look("evict0_new", 64'h140, 1, 1, 64'h240);
        upd(64'h160, 1, 64'h260);
        look("evict1_old", 64'h120, 0, 0, 64'h0);
        look("evict1_new", 64'h160, 1, 1, 64'h260);
        look("evict1_keep", 64'h140, 1, 1, 64'h240);

        upd(64'h180, 0, 64'h280);
        look("nt_noalloc", 64'h180, 0, 0, 64'h0);

        do_flush();
        stall = 1'b1;
        idle();
        stall = 1'b0;
        upd(64'h100, 1, 64'h300);
        look("stall_drop", 64'h100, 0, 0, 64'h0);
        upd(64'h100, 1, 64'h300);
        look("stall_ok", 64'h100, 1, 1, 64'h300);

        flush = 1'b1;
        upd(64'h1A0, 1, 64'h3A0);
        flush = 1'b0;
        look("flush_upd", 64'h1A0, 0, 0, 64'h0);
        look("flush_old", 64'h100, 0, 0, 64'h0);

        upd(64'h100, 1, 64'h400);
        look("pre_rst", 64'h100, 1, 1, 64'h400);
        #1 rst = 1'b1;
        look("mid_rst", 64'h100, 0, 0, 64'h0);
        idle();
        rst = 1'b0;
        idle();
        look("post_rst", 64'h100, 0, 0, 64'h0);

        for (int i = 0; i < 3000; i++) begin
            stall          = ($urandom_range(0, 99) < 20);
            flush          = ($urandom_range(0, 99) < 2);
            bus.upd_valid  = ($urandom_range(0, 99) < 60);
            bus.upd_taken  = ($urandom_range(0, 99) < 60);
            bus.upd_pc     = (64'($urandom_range(0, 4)) << 5) | (64'($urandom_range(0, 2)) << 1)
                             | 64'($urandom_range(0, 1));
            bus.upd_target = {$urandom, $urandom};
            bus.pc_if      = (64'($urandom_range(0, 4)) << 5) | (64'($urandom_range(0, 2)) << 1)
                             | 64'($urandom_range(0, 1));
            if (i == 1500) rst = 1'b1;
            idle();
            rst = 1'b0;
        end
        bus.upd_valid = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
